// File: rtl/fetch_decode_ctrl_if.sv
// Fetch/decode controller bus: instruction-memory port plus the decode
// fields and per-stage controls that flow into the 4-stage data path.
interface fetch_decode_ctrl_if #(parameter int PC_W = 30);
  logic [PC_W-1:0] instr_addr;
  logic [31:0]     instr_data;
  logic [29:0]     regRS;
  logic            zero;
  logic [4:0]      Rs, Rt, Rd;
  logic [15:0]     imm16;
  logic            ALUSource, Branch;
  logic [1:0]      ALUControl;
  logic            MemWrite;
  logic            RegWrite, MemToReg;
  logic [4:0]      WriteRegAddr;
  logic            stall;

  modport master (
    output instr_addr, Rs, Rt, Rd, imm16, ALUSource, Branch, ALUControl,
           MemWrite, RegWrite, MemToReg, WriteRegAddr, stall,
    input  instr_data, regRS, zero
  );

  modport slave (
    input  instr_addr, Rs, Rt, Rd, imm16, ALUSource, Branch, ALUControl,
           MemWrite, RegWrite, MemToReg, WriteRegAddr, stall,
    output instr_data, regRS, zero
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Fetch + decode/control stage. Owns the PC, decodes the IF/ID instruction,
// delays controls to the data-path stage that consumes them, resolves J/JR
// in ID and BEQ in EX, and stalls on RAW hazards (no forwarding downstream).
module fetch_decode_ctrl #(
  parameter int              PC_W     = 30,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 reset,
  fetch_decode_ctrl_if.master bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23,
                         OP_SW    = 6'h2B, OP_BEQ  = 6'h04, OP_J  = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A, FN_JR = 6'h08;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_SLT = 2'b11;

  // Nested so each stage register carries only what later stages still need.
  typedef struct packed { logic reg_write; logic mem_to_reg; logic [4:0] wr_addr; } wb_ctrl_t;
  typedef struct packed { logic mem_write; wb_ctrl_t wb; } mem_ctrl_t;
  typedef struct packed { logic branch; logic [1:0] alu_ctrl; mem_ctrl_t mem; } ex_ctrl_t;

  logic [PC_W-1:0] pc, pc_id, pc_ex, pc_next;
  logic [PC_W-1:0] imm_ext, br_target, pc_id_inc, j_target, jr_target;
  logic [31:0]     ir;
  logic [15:0]     imm_ex;
  ex_ctrl_t        ctrl_id, ctrl_ex;
  mem_ctrl_t       ctrl_mem;
  wb_ctrl_t        ctrl_wb;
  logic            alu_src, reads_rs, reads_rt, is_j, is_jr;
  logic            hazard, br_taken, redirect;
  logic [4:0]      rs, rt;

  assign rs = ir[25:21];
  assign rt = ir[20:16];

  // Decode the IF/ID instruction into controls and source-register usage.
  always_comb begin
    ctrl_id  = '0;
    alu_src  = 1'b0;
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    is_j     = 1'b0;
    is_jr    = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        if (ir[5:0] == FN_ADD || ir[5:0] == FN_SUB || ir[5:0] == FN_SLT) begin
          reads_rs                   = 1'b1;
          reads_rt                   = 1'b1;
          ctrl_id.mem.wb.reg_write   = 1'b1;
          ctrl_id.mem.wb.wr_addr     = ir[15:11];
          if (ir[5:0] == FN_SUB)      ctrl_id.alu_ctrl = ALU_SUB;
          else if (ir[5:0] == FN_SLT) ctrl_id.alu_ctrl = ALU_SLT;
          else                        ctrl_id.alu_ctrl = ALU_ADD;
        end else if (ir[5:0] == FN_JR) begin
          reads_rs = 1'b1;
          is_jr    = 1'b1;
        end
      end
      OP_ADDI: begin
        alu_src                  = 1'b1;
        reads_rs                 = 1'b1;
        ctrl_id.mem.wb.reg_write = 1'b1;
        ctrl_id.mem.wb.wr_addr   = rt;
      end
      OP_LW: begin
        alu_src                   = 1'b1;
        reads_rs                  = 1'b1;
        ctrl_id.mem.wb.reg_write  = 1'b1;
        ctrl_id.mem.wb.mem_to_reg = 1'b1;
        ctrl_id.mem.wb.wr_addr    = rt;
      end
      OP_SW: begin
        alu_src               = 1'b1;
        reads_rs              = 1'b1;
        reads_rt              = 1'b1;
        ctrl_id.mem.mem_write = 1'b1;
      end
      OP_BEQ: begin
        reads_rs         = 1'b1;
        reads_rt         = 1'b1;
        ctrl_id.branch   = 1'b1;
        ctrl_id.alu_ctrl = ALU_SUB;
      end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
    // r0 is hardwired; a write to it must never look like a pending producer.
    if (ctrl_id.mem.wb.wr_addr == 5'd0) ctrl_id.mem.wb.reg_write = 1'b0;
  end

  // RAW interlock: a source matches a pending write in EX or MEM (WB is safe,
  // the register file writes on the falling edge).
  always_comb begin
    hazard = 1'b0;
    if (reads_rs && ((ctrl_ex.mem.wb.reg_write && ctrl_ex.mem.wb.wr_addr == rs) ||
                     (ctrl_mem.wb.reg_write    && ctrl_mem.wb.wr_addr    == rs)))
      hazard = 1'b1;
    if (reads_rt && ((ctrl_ex.mem.wb.reg_write && ctrl_ex.mem.wb.wr_addr == rt) ||
                     (ctrl_mem.wb.reg_write    && ctrl_mem.wb.wr_addr    == rt)))
      hazard = 1'b1;
  end

  assign imm_ext   = {{(PC_W-16){imm_ex[15]}}, imm_ex};
  assign br_target = pc_ex + PC_W'(1) + imm_ext;
  assign pc_id_inc = pc_id + PC_W'(1);
  assign j_target  = (pc_id_inc & ~PC_W'(26'h3FF_FFFF)) | PC_W'(ir[25:0]);
  assign jr_target = PC_W'(bus.regRS);
  assign br_taken  = ctrl_ex.branch & bus.zero;

  // Next PC: taken branch beats stall, stall beats an ID jump.
  always_comb begin
    pc_next  = pc + PC_W'(1);
    redirect = 1'b0;
    if (br_taken)    pc_next = br_target;
    else if (hazard) pc_next = pc;
    else if (is_j)  begin pc_next = j_target;  redirect = 1'b1; end
    else if (is_jr) begin pc_next = jr_target; redirect = 1'b1; end
  end

  // PC and IF/ID register: hold on stall, load NOP on any redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      pc_id <= RESET_PC;
    end else begin
      pc <= pc_next;
      if (br_taken || redirect) ir <= '0;
      else if (!hazard) begin
        ir    <= bus.instr_data;
        pc_id <= pc;
      end
    end
  end

  // Control pipe EX -> MEM -> WB; a bubble enters EX on stall or branch flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_ex  <= '0;
      ctrl_mem <= '0;
      ctrl_wb  <= '0;
      pc_ex    <= '0;
      imm_ex   <= '0;
    end else begin
      ctrl_ex  <= (br_taken || hazard) ? '0 : ctrl_id;
      ctrl_mem <= ctrl_ex.mem;
      ctrl_wb  <= ctrl_mem.wb;
      pc_ex    <= pc_id;
      imm_ex   <= ir[15:0];
    end
  end

  assign bus.instr_addr   = pc;
  assign bus.Rs           = rs;
  assign bus.Rt           = rt;
  assign bus.Rd           = ir[15:11];
  assign bus.imm16        = ir[15:0];
  assign bus.ALUSource    = alu_src;
  assign bus.Branch       = ctrl_id.branch;
  assign bus.ALUControl   = ctrl_ex.alu_ctrl;
  assign bus.MemWrite     = ctrl_mem.mem_write;
  assign bus.RegWrite     = ctrl_wb.reg_write;
  assign bus.MemToReg     = ctrl_wb.mem_to_reg;
  assign bus.WriteRegAddr = ctrl_wb.wr_addr;
  assign bus.stall        = hazard;
endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: a small data path (register file, ALU, data
// memory) wraps the DUT, directed programs check cycle timing, and random
// programs are compared against an instruction-level interpreter.
module tb_fetch_decode_ctrl;
  logic clk, reset;
  fetch_decode_ctrl_if #(.PC_W(30)) bus ();
  fetch_decode_ctrl #(.PC_W(30), .RESET_PC(30'd0)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] rf [32];
  logic [31:0] rf_init [32];
  logic [31:0] dmem [256];
  logic [31:0] dm_init [256];
  logic [31:0] ex_a, ex_b, ex_sd, mem_res, mem_sd, wb_alu, wb_ld, alu_out;
  logic [36:0] rtrace [$];
  logic [39:0] mtrace [$];
  logic [36:0] exp_r [$];
  logic [39:0] exp_m [$];
  int total = 0, passed = 0, fails = 0, cyc = 0;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'b01:   return a - b;
      2'b11:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  assign bus.instr_data = imem[bus.instr_addr[7:0]];
  assign bus.regRS      = rf[bus.Rs][31:2];
  assign alu_out        = alu(ex_a, ex_b, bus.ALUControl);
  assign bus.zero       = (alu_out == 32'd0);

  // Data-path stage latches and data memory.
  always @(posedge clk) begin
    ex_a    <= rf[bus.Rs];
    ex_b    <= bus.ALUSource ? {{16{bus.imm16[15]}}, bus.imm16} : rf[bus.Rt];
    ex_sd   <= rf[bus.Rt];
    mem_res <= alu_out;
    mem_sd  <= ex_sd;
    wb_alu  <= mem_res;
    wb_ld   <= dmem[mem_res[7:0]];
    if (reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= dm_init[i];
      mtrace.delete();
    end else if (bus.MemWrite) begin
      dmem[mem_res[7:0]] <= mem_sd;
      mtrace.push_back({mem_res[7:0], mem_sd});
    end
  end

  // Register file writes on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_init[i];
      rtrace.delete();
    end else if (bus.RegWrite) begin
      rf[bus.WriteRegAddr] <= bus.MemToReg ? wb_ld : wb_alu;
      rtrace.push_back({bus.WriteRegAddr, bus.MemToReg ? wb_ld : wb_alu});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin imem[i] = 32'h0; dm_init[i] = 32'h0; end
    for (int i = 0; i < 32; i++) rf_init[i] = 32'h0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 11))
      0:       return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1:       return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      2:       return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      3, 4:    return {6'h08, rs, rt, 16'($urandom_range(0, 65535))};
      5:       return {6'h23, rs, rt, 16'($urandom_range(0, 15))};
      6:       return {6'h2B, rs, rt, 16'($urandom_range(0, 15))};
      7:       return {6'h04, rs, rt, 16'($urandom_range(0, 16)) - 16'd8};
      8:       return {6'h02, 26'($urandom_range(0, 255))};
      9:       return {6'h00, rs, 15'd0, 6'h08};
      10:      return {6'h3F, 26'($urandom)};
      default: return 32'h0;
    endcase
  endfunction

  // Instruction-at-a-time interpreter: architectural effects in program order.
  task automatic isa_run(input int steps);
    logic [31:0] r [32];
    logic [31:0] d [256];
    logic [29:0] pc, pc1, nxt;
    logic [31:0] ins, a, b, sx, wv;
    logic [4:0]  wd;
    logic        we;
    exp_r.delete();
    exp_m.delete();
    for (int i = 0; i < 32; i++) r[i] = rf_init[i];
    for (int i = 0; i < 256; i++) d[i] = dm_init[i];
    pc = 30'd0;
    repeat (steps) begin
      ins = imem[pc[7:0]];
      a   = r[ins[25:21]];
      b   = r[ins[20:16]];
      sx  = {{16{ins[15]}}, ins[15:0]};
      pc1 = pc + 30'd1;
      nxt = pc1;
      we  = 1'b0;
      wd  = 5'd0;
      wv  = 32'd0;
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h20: begin we = 1'b1; wd = ins[15:11]; wv = a + b; end
          6'h22: begin we = 1'b1; wd = ins[15:11]; wv = a - b; end
          6'h2A: begin we = 1'b1; wd = ins[15:11]; wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          6'h08: nxt = a[31:2];
          default: ;
        endcase
        6'h08: begin we = 1'b1; wd = ins[20:16]; wv = a + sx; end
        6'h23: begin we = 1'b1; wd = ins[20:16]; wv = d[8'(a + sx)]; end
        6'h2B: begin d[8'(a + sx)] = b; exp_m.push_back({8'(a + sx), b}); end
        6'h04: if (a == b) nxt = pc1 + sx[29:0];
        6'h02: nxt = {pc1[29:26], ins[25:0]};
        default: ;
      endcase
      if (we && wd != 5'd0) begin
        r[wd] = wv;
        exp_r.push_back({wd, wv});
      end
      pc = nxt;
    end
  endtask

  initial begin
    reset = 1'b1;
    // Reset state, then ADDI r1,r0,4 timing through the control pipe.
    clear_all();
    imem[0] = 32'h20010004;
    do_reset();
    chk("rst_addr", bus.instr_addr, 0);
    chk("rst_en", {bus.RegWrite, bus.MemWrite, bus.MemToReg, bus.stall}, 0);
    chk("rst_fields", {bus.Rs, bus.Rt, bus.Rd, bus.imm16, bus.ALUControl, bus.WriteRegAddr}, 0);
    tick();
    chk("t1_addr1", bus.instr_addr, 1);
    chk("t1_dec", {bus.Rs, bus.Rt, bus.imm16, bus.ALUSource}, {5'd0, 5'd1, 16'd4, 1'b1});
    tick();
    chk("t1_ex", {bus.instr_addr, bus.ALUControl}, {30'd2, 2'b00});
    to_cyc(4);
    chk("t1_wb", {bus.RegWrite, bus.WriteRegAddr, bus.stall}, {1'b1, 5'd1, 1'b0});
    tick();
    chk("t1_rf", rf[1], 4);

    // ADDI r1 then ADD r3,r1,r1: two stall cycles holding PC at 2.
    clear_all();
    imem[0] = 32'h20010004;
    imem[1] = 32'h00211820;
    do_reset();
    to_cyc(2);
    chk("t2_stall2", {bus.stall, bus.instr_addr}, {1'b1, 30'd2});
    tick();
    chk("t2_stall3", {bus.stall, bus.instr_addr}, {1'b1, 30'd2});
    tick();
    chk("t2_go4", {bus.stall, bus.instr_addr, bus.RegWrite}, {1'b0, 30'd2, 1'b1});
    tick();
    chk("t2_bub5", {bus.RegWrite, bus.instr_addr}, {1'b0, 30'd3});
    tick();
    chk("t2_bub6", bus.RegWrite, 0);
    tick();
    chk("t2_add_wb", {bus.RegWrite, bus.WriteRegAddr}, {1'b1, 5'd3});
    tick();
    chk("t2_rf", rf[3], 8);

    // BEQ r0,r0,+5 at 4 taken -> 10; J 0x40; JR to 0x100.
    clear_all();
    imem[4]    = 32'h10000005;
    imem[5]    = 32'h20020007;
    imem[6]    = 32'h20030007;
    imem[10]   = 32'h20040009;
    imem[11]   = 32'h08000040;
    imem[12]   = 32'h20050001;
    imem[8'h40] = 32'h20060400;
    imem[8'h43] = 32'h00C00008;
    do_reset();
    to_cyc(6);
    chk("t3_beq_ex", bus.ALUControl, 2'b01);
    tick();
    chk("t3_target", bus.instr_addr, 10);
    for (int c = 8; c <= 10; c++) begin
      to_cyc(c);
      chk("t3_flush_we", {bus.RegWrite, bus.MemWrite}, 0);
      if (c == 10) chk("t3_j_target", bus.instr_addr, 30'h40);
    end
    tick();
    chk("t3_addi_wb", {bus.RegWrite, bus.WriteRegAddr}, {1'b1, 5'd4});
    to_cyc(15);
    chk("t3_jr_target", bus.instr_addr, 30'h100);
    chk("t3_regs", {rf[2], rf[3], rf[5]}, 0);
    chk("t3_rf4_rf6", {rf[4], rf[6]}, {32'd9, 32'h400});

    // SW store timing, then LW with a dependent ADD (2-cycle stall).
    clear_all();
    imem[0] = 32'h20010004;
    imem[3] = 32'hAC010001;
    imem[4] = 32'h8C020001;
    imem[5] = 32'h00422020;
    do_reset();
    to_cyc(5);
    chk("t5_mw5", bus.MemWrite, 0);
    tick();
    chk("t5_mw6", {bus.MemWrite, bus.stall}, {1'b1, 1'b1});
    tick();
    chk("t5_mw7", {bus.MemWrite, bus.RegWrite, bus.stall}, {1'b0, 1'b0, 1'b1});
    tick();
    chk("t5_lw_wb", {bus.stall, bus.RegWrite, bus.MemToReg, bus.WriteRegAddr}, {1'b0, 1'b1, 1'b1, 5'd2});
    to_cyc(11);
    chk("t5_add_wb", {bus.RegWrite, bus.MemToReg, bus.WriteRegAddr}, {1'b1, 1'b0, 5'd4});
    tick();
    chk("t5_mem", {dmem[1], rf[4]}, {32'd4, 32'd8});

    // Reset while BEQ is in EX and ADD is stalled; illegal opcode never writes.
    clear_all();
    imem[0]  = 32'h20010004;
    imem[1]  = 32'h10000008;
    imem[2]  = 32'h00211820;
    imem[10] = 32'hFFFFFFFF;
    imem[11] = 32'h20070005;
    do_reset();
    to_cyc(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
    chk("t6_addr", bus.instr_addr, 0);
    for (int c = 0; c < 3; c++) begin
      to_cyc(c);
      chk("t6_we_clear", {bus.RegWrite, bus.MemWrite, bus.MemToReg, bus.ALUControl}, 0);
    end
    to_cyc(20);
    chk("t6_nwrites", rtrace.size(), 2);
    chk("t6_nstores", mtrace.size(), 0);
    if (rtrace.size() == 2) chk("t6_trace", {rtrace[0], rtrace[1]}, {5'd1, 32'd4, 5'd7, 32'd5});
    chk("t6_regs", {rf[3], rf[31]}, 0);

    // Random programs vs. the instruction-level interpreter.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 256; i++) begin imem[i] = rand_instr(); dm_init[i] = $urandom; end
      rf_init[0] = 32'h0;
      for (int i = 1; i < 32; i++) rf_init[i] = $urandom;
      isa_run(300);
      do_reset();
      to_cyc(1500);
      chk("rnd_rlen", 64'(rtrace.size() >= exp_r.size()), 1);
      chk("rnd_mlen", 64'(mtrace.size() >= exp_m.size()), 1);
      for (int i = 0; i < exp_r.size(); i++)
        if (i < rtrace.size()) chk("rnd_regwr", rtrace[i], exp_r[i]);
      for (int i = 0; i < exp_m.size(); i++)
        if (i < mtrace.size()) chk("rnd_store", mtrace[i], exp_m[i]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
